// File: rtl/mdio_pkg.sv
// Shared definitions for the multi-PHY MDIO management controller:
// register map, speed codes, FSM encoding and small decode helpers.
package mdio_pkg;

  // Clause-22 register addresses touched by the controller
  localparam logic [4:0] REG_BMCR  = 5'd0;
  localparam logic [4:0] REG_BMSR  = 5'd1;
  localparam logic [4:0] REG_PHYSR = 5'h11;

  // Per-PHY speed codes as presented on the speed/led outputs
  localparam logic [1:0] SPD_1000 = 2'b11;
  localparam logic [1:0] SPD_100  = 2'b10;
  localparam logic [1:0] SPD_10   = 2'b01;
  localparam logic [1:0] SPD_UNK  = 2'b00;

  // BMSR bit positions
  localparam int BMSR_LINK      = 2;
  localparam int BMSR_ANEG_DONE = 5;

  // Controller FSM encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR_BMCR  = 3'd1;
  localparam logic [2:0] ST_RD_BMSR  = 3'd2;
  localparam logic [2:0] ST_RD_PHYSR = 3'd3;
  localparam logic [2:0] ST_WAIT     = 3'd4;
  localparam logic [2:0] ST_NEXT     = 3'd5;

  // Which operation is outstanding while the FSM sits in WAIT
  typedef enum logic [1:0] {
    OP_RST_WR = 2'd0,
    OP_BMSR   = 2'd1,
    OP_PHYSR  = 2'd2
  } op_kind_t;

  // PHYSR[15:14] speed field to output speed code
  function automatic logic [1:0] physr_speed(input logic [1:0] field);
    case (field)
      2'b10:   return SPD_1000;
      2'b01:   return SPD_100;
      2'b00:   return SPD_10;
      default: return SPD_UNK;
    endcase
  endfunction

  // Index of the lowest set bit (0 when none set)
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mdio_trig_sync.sv
// Brings one asynchronous soft-reset request level into the clk domain
// and emits a single-cycle pulse on each rising edge.
module mdio_trig_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic sync1, sync2, prev;

  // Two-flop synchroniser followed by an edge-detect history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value
      // of its predecessor; blocking here would collapse the chain.
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/mdio_multi_phy_ctrl.sv
// Multi-PHY MDIO management controller: per-PHY soft reset, periodic
// round-robin link/speed polling and an operation timeout watchdog,
// issuing requests to the MDIO bit-level driver via op_exec/op_done.
module mdio_multi_phy_ctrl
  import mdio_pkg::*;
#(
  parameter int          NUM_PHY       = 2,
  parameter logic [4:0]  PHY_ADDR_BASE = 5'd1,
  parameter logic [23:0] POLL_CYCLES   = 24'd1_000_000,
  parameter logic [15:0] OP_TIMEOUT    = 16'd4096,
  parameter logic [15:0] RST_WR_DATA   = 16'h9140
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PHY-1:0]     soft_rst_trig,
  input  logic                   op_done,
  input  logic [15:0]            op_rd_data,
  input  logic                   op_rd_ack,
  output logic                   op_exec,
  output logic                   op_rh_wl,
  output logic [4:0]             op_phy_addr,
  output logic [4:0]             op_reg_addr,
  output logic [15:0]            op_wr_data,
  output logic [NUM_PHY-1:0]     link_up,
  output logic [2*NUM_PHY-1:0]   speed,
  output logic [2*NUM_PHY-1:0]   led,
  output logic                   timeout_err
);

  logic [NUM_PHY-1:0] trig_rise, rst_pend, rst_clr;
  logic [7:0]         pend_wide;
  logic [23:0]        poll_cnt;
  logic               poll_tick, poll_pend, poll_take;
  logic [2:0]         state, idx, resume_idx;
  logic               resume_vld;
  op_kind_t           op_kind;
  logic [15:0]        wait_cnt;
  logic               bmsr_ok, wait_expire;
  logic               st_upd, st_link;
  logic [1:0]         st_speed;

  for (genvar g = 0; g < NUM_PHY; g++) begin : g_sync
    mdio_trig_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (soft_rst_trig[g]),
      .rise     (trig_rise[g])
    );
  end

  // Zero-extend the pending vector for the priority helper
  always_comb begin
    pend_wide                = '0;
    pend_wide[NUM_PHY-1:0]   = rst_pend;
  end

  assign poll_tick   = (poll_cnt == POLL_CYCLES - 24'd1);
  assign poll_take   = (state == ST_IDLE) && (rst_pend == '0) && !resume_vld && poll_pend;
  assign wait_expire = (state == ST_WAIT) && !op_done && (wait_cnt == OP_TIMEOUT - 16'd1);
  assign bmsr_ok     = !op_rd_ack && op_rd_data[BMSR_ANEG_DONE] && op_rd_data[BMSR_LINK];

  // Free-running sweep timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            poll_cnt <= '0;
    else if (poll_tick) poll_cnt <= '0;
    else                poll_cnt <= poll_cnt + 24'd1;
  end

  // One-deep sweep request; a tick coinciding with a take stays latched
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            poll_pend <= 1'b0;
    else if (poll_tick) poll_pend <= 1'b1;
    else if (poll_take) poll_pend <= 1'b0;
  end

  // Reset-write completion (or abort) releases that PHY's pending request
  always_comb begin
    // NOTE: assigning a default first keeps this block purely combinational;
    // a path that leaves a variable unassigned would infer a latch.
    rst_clr = '0;
    if ((state == ST_WAIT) && (op_kind == OP_RST_WR) && (op_done || wait_expire)) begin
      for (int i = 0; i < NUM_PHY; i++) begin
        if (idx == 3'(i)) rst_clr[i] = 1'b1;
      end
    end
  end

  // Per-PHY reset requests; edges arriving while already pending are absorbed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pend <= '0;
    else     rst_pend <= (rst_pend | trig_rise) & ~rst_clr;
  end

  // Status update for the PHY under service, derived from the op result
  always_comb begin
    st_upd   = 1'b0;
    st_link  = 1'b0;
    st_speed = SPD_UNK;
    if (state == ST_WAIT) begin
      if (op_done) begin
        if (op_kind == OP_BMSR && !bmsr_ok) begin
          st_upd = 1'b1;
        end else if (op_kind == OP_PHYSR) begin
          st_upd = 1'b1;
          if (!op_rd_ack) begin
            st_link  = 1'b1;
            st_speed = physr_speed(op_rd_data[15:14]);
          end
        end
      end else if (wait_expire) begin
        st_upd = 1'b1;
      end
    end
  end

  // Per-PHY link/speed registers and the sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_up     <= '0;
      speed       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (st_upd) begin
        for (int i = 0; i < NUM_PHY; i++) begin
          if (idx == 3'(i)) begin
            link_up[i]       <= st_link;
            speed[2*i +: 2]  <= st_speed;
          end
        end
      end
      if (wait_expire) timeout_err <= 1'b1;
    end
  end

  // LEDs show the speed code only while the link is up
  always_comb begin
    led = '0;
    for (int i = 0; i < NUM_PHY; i++) begin
      if (link_up[i]) led[2*i +: 2] = speed[2*i +: 2];
    end
  end

  // Sequencer: pick work in IDLE, issue one op, wait for it, advance the sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      resume_idx  <= '0;
      resume_vld  <= 1'b0;
      op_kind     <= OP_RST_WR;
      wait_cnt    <= '0;
      op_exec     <= 1'b0;
      op_rh_wl    <= 1'b0;
      op_phy_addr <= '0;
      op_reg_addr <= '0;
      op_wr_data  <= '0;
    end else begin
      op_exec <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rst_pend != '0) begin
            idx   <= lowest_set(pend_wide);
            state <= ST_WR_BMCR;
          end else if (resume_vld) begin
            idx        <= resume_idx;
            resume_vld <= 1'b0;
            state      <= ST_RD_BMSR;
          end else if (poll_pend) begin
            idx   <= '0;
            state <= ST_RD_BMSR;
          end
        end
        ST_WR_BMCR: begin
          op_exec     <= 1'b1;
          op_rh_wl    <= 1'b0;
          op_phy_addr <= PHY_ADDR_BASE + {2'b00, idx};
          op_reg_addr <= REG_BMCR;
          op_wr_data  <= RST_WR_DATA;
          op_kind     <= OP_RST_WR;
          wait_cnt    <= '0;
          state       <= ST_WAIT;
        end
        ST_RD_BMSR: begin
          op_exec     <= 1'b1;
          op_rh_wl    <= 1'b1;
          op_phy_addr <= PHY_ADDR_BASE + {2'b00, idx};
          op_reg_addr <= REG_BMSR;
          op_kind     <= OP_BMSR;
          wait_cnt    <= '0;
          state       <= ST_WAIT;
        end
        ST_RD_PHYSR: begin
          op_exec     <= 1'b1;
          op_rh_wl    <= 1'b1;
          op_phy_addr <= PHY_ADDR_BASE + {2'b00, idx};
          op_reg_addr <= REG_PHYSR;
          op_kind     <= OP_PHYSR;
          wait_cnt    <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (op_done) begin
            case (op_kind)
              OP_RST_WR: state <= ST_IDLE;
              OP_BMSR:   state <= bmsr_ok ? ST_RD_PHYSR : ST_NEXT;
              default:   state <= ST_NEXT;
            endcase
          end else if (wait_expire) begin
            state <= (op_kind == OP_RST_WR) ? ST_IDLE : ST_NEXT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_NEXT: begin
          if (idx == 3'(NUM_PHY - 1)) begin
            state <= ST_IDLE;
          end else if (rst_pend != '0) begin
            resume_idx <= idx + 3'd1;
            resume_vld <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            idx   <= idx + 3'd1;
            state <= ST_RD_BMSR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
